mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with fixed latencies and performs mthi/mtlo writes.
- Exposes busy for hazard-unit stalls and provides the mfhi/mflo read value, which travels through the M and W pipeline registers to the register file.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy duration for div/divu (must be >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  E-stage instruction is an MDU op; qualifies op
op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
rs_data  input  32  forwarded rs operand
rt_data  input  32  forwarded rt operand
out_sel  input  1  0 selects LO, 1 selects HI for mdu_out
busy  output  1  operation in flight
stall_req  output  1  busy | (start & op in 1..4); consumed by the hazard unit for mf*/mt*/md ops
hi_out  output  32  architectural HI
lo_out  output  32  architectural LO
mdu_out  output  32  out_sel ? hi_out : lo_out, combinational

Behaviour:
- Reset (asynchronous, while reset=1):
  - hi, lo, pending_hi, pending_lo, cnt, op_latched all cleared to 0.
  - busy=0, mdu_out=0.
  - An in-flight operation is discarded with no commit.
- Accept condition: start=1 and busy=0 at a rising edge.
  - With busy=1, every start is ignored, including MTHI/MTLO.
  - The hazard unit must hold the instruction in E; the MDU does not queue it.
- MULT/MULTU/DIV/DIVU accepted at edge T:
  - Operands are computed and latched into pending_hi/pending_lo at edge T.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 for exactly N cycles after edge T.
  - At the edge where cnt==1: cnt goes to 0, hi/lo take the pending values, and busy falls.
  - New HI/LO are visible in the same cycle busy reads 0.
- MULT: signed 32x32 -> 64; HI = [63:32], LO = [31:0]. MULTU is the unsigned equivalent.
- DIV (signed): quotient truncates toward zero; remainder takes the sign of the dividend; LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (rt_data==0):
  - busy still runs DIV_CYCLES.
  - The commit is suppressed; hi/lo keep their previous values.
- MTHI/MTLO accepted at edge T:
  - hi (or lo) is set to rs_data at edge T.
  - busy stays 0; zero-cycle latency.
- NOP or reserved op: no state change.
- State: IDLE (cnt==0) -> BUSY (cnt!=0) on accept of a mult/div op; BUSY -> IDLE when cnt reaches 0.
  - A new start in the edge leaving BUSY is not accepted: busy is still 1 at that edge.
  - Back-to-back issue therefore gives N busy cycles, 1 idle cycle, then the next op.
- cnt width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- mdu_out and hi_out/lo_out always show committed values, never pending ones.

Optional Feature:
- Macro MDU_CANCEL_EN adds input port cancel (1 bit), used for the exception flush in P7.
- With the macro defined:
  - cancel=1 at an edge while busy clears cnt to 0 and drops pending_hi/pending_lo; hi/lo are not written; busy=0 the next cycle.
  - cancel=1 and start=1 together: cancel wins and start is ignored, including MTHI/MTLO.
  - cancel has no effect when idle, apart from blocking start.
- Without the macro: the port is absent, and every accepted operation always completes.

Test Plan:
1. MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
2. DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy high exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
3. MTHI rs=0x12345678 while idle -> hi_out=0x12345678 next cycle, busy never rises. Issue MTLO 0xAAAA during a MULT busy window -> ignored; lo shows the MULT result only.
4. DIV rs=100 rt=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
5. Assert reset asynchronously mid-clock during cycle 3 of a MULT -> busy, hi_out, lo_out go to 0 before the next edge; no commit afterward.
6. (MDU_CANCEL_EN) MULT 3*4, cancel on busy cycle 2 -> busy=0 next cycle; HI/LO keep old values. Next MULT 3*4 -> LO=0xC after 5 cycles.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional macro MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        out_sel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mdu_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_DIV,
        OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic          commit_q, commit_d;

    logic          cancel_w;
    logic          accept;
    op_e           op_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign op_w   = op_e'(op);
    assign accept = start & (state_q == S_IDLE) & ~cancel_w;

    // One shared multiplier and one shared magnitude divider for both signednesses.
    logic        sgn;
    logic [63:0] mul_a, mul_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] dvd_mag, dvs_mag;
    logic [31:0] quo_mag, rem_mag;
    logic [31:0] quo, rem;

    always_comb begin
        sgn     = (op_w == OP_MULT) || (op_w == OP_DIV);
        mul_a   = {{32{sgn & rs_data[31]}}, rs_data};
        mul_b   = {{32{sgn & rt_data[31]}}, rt_data};
        prod    = mul_a * mul_b;
        a_neg   = sgn & rs_data[31];
        b_neg   = sgn & rt_data[31];
        dvd_mag = a_neg ? (32'd0 - rs_data) : rs_data;
        dvs_mag = b_neg ? (32'd0 - rt_data) : rt_data;
        if (dvs_mag == 32'd0) begin
            dvs_mag = 32'd1;
        end
        quo_mag = dvd_mag / dvs_mag;
        rem_mag = dvd_mag % dvs_mag;
        quo     = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem     = a_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        commit_d = commit_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_w)
                        OP_MULT, OP_MULTU: begin
                            phi_d    = prod[63:32];
                            plo_d    = prod[31:0];
                            commit_d = 1'b1;
                            cnt_d    = MULT_N;
                            state_d  = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            phi_d    = rem;
                            plo_d    = quo;
                            commit_d = (rt_data != 32'd0);
                            cnt_d    = DIV_N;
                            state_d  = S_BUSY;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cancel_w) begin
                    cnt_d    = '0;
                    phi_d    = 32'd0;
                    plo_d    = 32'd0;
                    commit_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == ONE) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (commit_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            commit_q <= commit_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign stall_req = busy | (start & (op >= 3'd1) & (op <= 3'd4));
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign mdu_out   = out_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: issue pushes expected HI/LO and busy length,
// a negedge monitor pops and compares on every completed busy window.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_sel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mdu_out;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MDU_CANCEL_EN
        .cancel    (cancel),
`endif
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .out_sel   (out_sel),
        .busy      (busy),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .mdu_out   (mdu_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on the operands.
    function automatic void model_apply(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                m_lo = 32'(sa / sb);
                m_hi = 32'(sa % sb);
            end
            3'd4: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic void push_exp(input int cyc);
        exp_t e;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.cyc = cyc;
        exp_q.push_back(e);
    endfunction

    // Monitor: measures each busy window and checks the committed result.
    initial begin : monitor
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
            end else if (busy) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: busy ran %0d cycles, none pending", run);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("busy_len", 32'(run), 32'(e.cyc));
                    check("hi_out", hi_out, e.hi);
                    check("lo_out", lo_out, e.lo);
                    check("mdu_out", mdu_out, out_sel ? e.hi : e.lo);
                end
                run = 0;
            end
        end
    end

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            total++;
            bad++;
            $display("FAIL timeout: busy=%0b pending=%0d want idle", busy, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue_md(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        model_apply(o, a, b);
        push_exp((o <= 3'd2) ? MC : DC);
        @(posedge clk); #2;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        #1 check("stall_req_md", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        wait_done();
    endtask

    task automatic issue_other(input logic [2:0] o, input logic [31:0] a);
        model_apply(o, a, 32'd0);
        @(posedge clk); #2;
        start = 1'b1; op = o; rs_data = a; rt_data = $urandom;
        #1 check("stall_req_mt", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", hi_out, m_hi);
        check("mt_lo", lo_out, m_lo);
    endtask

    initial begin : stim
        logic [2:0]  o;
        logic [31:0] a, b;
        int          k;
        reset = 1'b1; start = 1'b0; op = 3'd0;
        rs_data = 32'd0; rt_data = 32'd0; out_sel = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_mdu_out", mdu_out, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        issue_md(3'd1, 32'hFFFFFFFF, 32'h2);
        check("t1_mult_hi", hi_out, 32'hFFFFFFFF);
        check("t1_mult_lo", lo_out, 32'hFFFFFFFE);
        issue_md(3'd2, 32'hFFFFFFFF, 32'h2);
        check("t1_multu_hi", hi_out, 32'h1);
        check("t1_multu_lo", lo_out, 32'hFFFFFFFE);

        issue_md(3'd3, 32'hFFFFFFF9, 32'h2);
        check("t2_div_hi", hi_out, 32'hFFFFFFFF);
        check("t2_div_lo", lo_out, 32'hFFFFFFFD);
        issue_md(3'd4, 32'd7, 32'd2);
        check("t2_divu_hi", hi_out, 32'd1);
        check("t2_divu_lo", lo_out, 32'd3);
        issue_md(3'd3, 32'h80000000, 32'hFFFFFFFF);
        check("ovf_div_hi", hi_out, 32'h0);
        check("ovf_div_lo", lo_out, 32'h80000000);

        issue_other(3'd5, 32'h12345678);
        check("t3_mthi", hi_out, 32'h12345678);

        // MTLO while a MULT is in flight must be dropped.
        model_apply(3'd1, 32'd6, 32'd7);
        push_exp(MC);
        @(posedge clk); #2;
        start = 1'b1; op = 3'd1; rs_data = 32'd6; rt_data = 32'd7;
        @(posedge clk); #2;
        op = 3'd6; rs_data = 32'hAAAA;
        #1 check("t3_stall_busy", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        wait_done();
        check("t3_lo_mult", lo_out, 32'd42);

        issue_other(3'd5, 32'h11);
        issue_other(3'd6, 32'h22);
        issue_md(3'd3, 32'd100, 32'd0);
        check("t4_dz_hi", hi_out, 32'h11);
        check("t4_dz_lo", lo_out, 32'h22);
        issue_md(3'd4, 32'd5, 32'd0);
        check("t4_dzu_lo", lo_out, 32'h22);

        // Asynchronous reset in the middle of busy cycle 3.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_hi", hi_out, 32'd0);
        check("t5_lo", lo_out, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        exp_q.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_nocommit_hi", hi_out, 32'd0);
        check("t5_nocommit_lo", lo_out, 32'd0);

        // Back-to-back: start held high, second op must wait one idle cycle.
        model_apply(3'd1, 32'hFFFF0000, 32'h00010003);
        push_exp(MC);
        model_apply(3'd4, 32'd1000, 32'd7);
        push_exp(DC);
        @(posedge clk); #2;
        start = 1'b1; op = 3'd1; rs_data = 32'hFFFF0000; rt_data = 32'h00010003;
        @(posedge clk); #2;
        op = 3'd4; rs_data = 32'd1000; rt_data = 32'd7;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        k = 0;
        while (!busy && k < 5) begin
            @(posedge clk); #2;
            k++;
        end
        check("b2b_reissue", {31'd0, busy}, 32'd1);
        start = 1'b0; op = 3'd0;
        wait_done();

`ifdef MDU_CANCEL_EN
        a = m_hi;
        b = m_lo;
        push_exp(2);
        @(posedge clk); #2;
        start = 1'b1; op = 3'd1; rs_data = 32'd3; rt_data = 32'd4;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        @(posedge clk); #2;
        cancel = 1'b1;
        @(posedge clk); #2;
        cancel = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        wait_done();
        check("t6_hi_kept", hi_out, a);
        check("t6_lo_kept", lo_out, b);
        issue_md(3'd1, 32'd3, 32'd4);
        check("t6_lo", lo_out, 32'hC);
`endif

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            out_sel = 1'($urandom_range(0, 1));
            if (o >= 3'd1 && o <= 3'd4) issue_md(o, a, b);
            else issue_other(o, a);
        end

        wait_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
